turn_signal_input_cond: RTL
===========================

// Module: turn_signal_input_cond
// PURPOSE
//  Conditions the raw turn-signal switches before they reach the tail-light sequencer FSM.
//  Synchronises left/right into clk, debounces each channel and generates the step-enable tick.
//  Presents left_req/right_req that are stable across each step period.
//  Sits directly upstream of the sequencer; its outputs drive the sequencer's left/right/enable.
// PARAMETERS
//  DB_CNT    4  consecutive stable synchronised cycles required to accept a level change (>=1)
//  STEP_DIV  8  clk cycles per step_en pulse (>=1); counter width $clog2(STEP_DIV), min 1 bit
// PORTS
//  clk        in   1  single system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  left_raw   in   1  asynchronous left switch level
//  right_raw  in   1  asynchronous right switch level
//  left_db    out  1  debounced left level
//  right_db   out  1  debounced right level
//  left_req   out  1  left request, updated only on step edges
//  right_req  out  1  right request, updated only on step edges
//  step_en    out  1  one-cycle step strobe for the sequencer
// BEHAVIOUR
//  Reset: rst sampled high on an edge -> all flops clear; every output is 0 the following cycle.
//   Applies mid-debounce and mid-step: no state survives.
//  Edge numbering: edge 1 = first rising edge sampling rst=0.
//  Sync: 2 flops per channel (s1 <= raw; s2 <= s1). Raw change before edge e -> s2 changes after e+1.
//  Debounce, per channel, counter dc (width $clog2(DB_CNT), min 1):
//   s2 == db                     -> dc <= 0
//   s2 != db, dc <  DB_CNT-1     -> dc <= dc+1
//   s2 != db, dc == DB_CNT-1     -> db <= s2, dc <= 0
//   Result: a level held through edges e..e+DB_CNT+1 sets db after edge e+DB_CNT+1.
//   Total latency: DB_CNT+2 edges (6 at default).
//   Any return of s2 to db before acceptance clears dc, so glitches shorter than DB_CNT synced cycles never reach db.
//   Press and release use the same rule.
//  Step tick:
//   sc increments every edge and wraps from STEP_DIV-1 to 0.
//   step_en <= (sc == STEP_DIV-1), a registered single-cycle pulse.
//   Pulse is high after edges STEP_DIV, 2*STEP_DIV, ...
//   STEP_DIV=1: step_en high continuously from after edge 1.
//  Requests: on the edge where sc == STEP_DIV-1: left_req <= left_db, right_req <= right_db.
//   Otherwise both hold.
//   Fresh values are visible in the same cycle step_en is high.
//  Both channels are independent. Simultaneous left/right is passed through unchanged (both reqs high).
//   Hazard interpretation belongs to the sequencer.
//  No combinational path from any input to any output.
// TESTING  (DB_CNT=4, STEP_DIV=8)
//  1. rst=1 for 3 edges with left_raw=right_raw=1 -> all outputs 0 during reset and in the cycle after.
//  2. rst released, inputs 0 -> step_en high only after edges 8,16,24, exactly 1 cycle wide; reqs stay 0.
//  3. left_raw 0->1 before edge 3 and held -> left_db rises after edge 8.
//     left_req and step_en both rise after edge 8; right_* stay 0.
//  4. left_raw high for 3 edges only -> left_db, left_req stay 0.
//     Repeat with a 1-cycle low dropout on a held press -> acceptance restarts, delayed by the dropout.
//  5. left_raw, right_raw both 0->1 before edge 10 -> both db rise after edge 15.
//     Both reqs rise together after edge 16.
//  6. left_raw held 1, rst pulsed at edge 6 mid-debounce -> left_db 0.
//     After release, left_db rises DB_CNT+2 edges after the new edge 1; the step count restarts from the new edge 1.

Source files
------------

// File: rtl/turn_signal_input_cond.sv
// turn_signal_input_cond
//   Conditions the raw turn-signal switches for the tail-light sequencer.
//   Each channel is synchronised with two flops and then debounced. A free-running
//   divider produces the step strobe. The request outputs are re-sampled only on step
//   edges, so they hold steady for a whole step period.
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset; clears every flop
//   left_raw   asynchronous left switch level
//   right_raw  asynchronous right switch level
//   left_db    debounced left level
//   right_db   debounced right level
//   left_req   left request, updated on step edges only
//   right_req  right request, updated on step edges only
//   step_en    one-cycle step strobe, high every STEP_DIV cycles

// tsic_chan: one synchroniser + debouncer channel.
//   raw    asynchronous input level
//   db     debounced level (registered)
//   db_nxt value db takes on the coming edge (decoded from flops only)
module tsic_chan #(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic db_nxt
);
  localparam int DCW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [DCW-1:0] DC_MAX = DCW'(DB_CNT - 1);

  logic           s1, s2;
  logic [DCW-1:0] dc, dc_nxt;

  // dc counts consecutive synced cycles that disagree with db; any agreeing
  // cycle drops it back to zero, so only an unbroken run is accepted.
  always_comb begin
    db_nxt = db;
    dc_nxt = '0;
    if (s2 != db) begin
      if (dc == DC_MAX) db_nxt = s2;
      else              dc_nxt = dc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      dc <= '0;
      db <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      dc <= dc_nxt;
      db <= db_nxt;
    end
  end
endmodule

module turn_signal_input_cond #(
  parameter int DB_CNT   = 4,
  parameter int STEP_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic left_raw,
  input  logic right_raw,
  output logic left_db,
  output logic right_db,
  output logic left_req,
  output logic right_req,
  output logic step_en
);
  localparam int NUM_CH = 2;
  localparam int SCW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SCW-1:0] SC_MAX = SCW'(STEP_DIV - 1);

  // channel 0 = left, channel 1 = right
  logic [NUM_CH-1:0] raw, db, db_nxt, req;
  logic [SCW-1:0]    sc;
  logic              step_edge;

  assign raw = {right_raw, left_raw};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    tsic_chan #(.DB_CNT(DB_CNT)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[ch]),
      .db     (db[ch]),
      .db_nxt (db_nxt[ch])
    );
  end

  assign step_edge = (sc == SC_MAX);

  // Requests take db_nxt, so a level accepted on the step edge itself is
  // already visible in the same cycle that step_en is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc      <= '0;
      step_en <= 1'b0;
      req     <= '0;
    end else begin
      sc      <= step_edge ? '0 : sc + 1'b1;
      step_en <= step_edge;
      if (step_edge) req <= db_nxt;
    end
  end

  assign left_db   = db[0];
  assign right_db  = db[1];
  assign left_req  = req[0];
  assign right_req = req[1];
endmodule
